// File: rtl/lockstep_compare_if.sv
// OBI request type and the bundle of four time-aligned request channels
// (leading/trailing hart, instruction/data) that feeds the lockstep checker.
package lockstep_pkg;
    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;
endpackage

interface lockstep_compare_if;
    lockstep_pkg::obi_req_t instr_a;
    lockstep_pkg::obi_req_t instr_b;
    lockstep_pkg::obi_req_t data_a;
    lockstep_pkg::obi_req_t data_b;

    modport master (output instr_a, output instr_b, output data_a, output data_b);
    modport slave  (input  instr_a, input  instr_b, input  data_a, input  data_b);
endinterface

// File: rtl/lockstep_compare.sv
// Lockstep checker: compares aligned leading/trailing hart OBI requests each
// cycle, counts mismatches and latches a sticky fault with address capture.
//
// state  | meaning
// IDLE   | lockstep disabled, no comparison
// WARMUP | upstream delay line filling, comparisons ignored for NCYCLES cycles
// CHECK  | requests compared every cycle, mismatches counted
// FAULT  | threshold reached; outputs and captures frozen until clear/reset
module lockstep_compare
    import lockstep_pkg::*;
#(
    parameter int unsigned NCYCLES       = 2,
    parameter int unsigned ERR_THRESHOLD = 1,
    parameter int unsigned CNT_W         = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  clear_i,
    lockstep_compare_if.slave     req_if,
    output logic                  mismatch_o,
    output logic [CNT_W-1:0]      mismatch_cnt_o,
    output logic                  fault_o,
    output logic                  fault_irq_o,
    output logic [31:0]           fault_addr_o,
    output logic [1:0]            fault_src_o,
    output logic [1:0]            state_o
);

    localparam int unsigned WARM_W = (NCYCLES > 1) ? $clog2(NCYCLES) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(NCYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_THR   = CNT_W'(ERR_THRESHOLD);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FAULT  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [WARM_W-1:0]   warm_q, warm_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [31:0]         addr_q, addr_d;
    logic [1:0]          src_q, src_d;
    logic                mis_q, mis_d;
    logic                irq_q, irq_d;

    logic                instr_mis;
    logic                data_mis;
    logic                cyc_mis;
    logic [CNT_W-1:0]    cnt_inc;

    // Read data is irrelevant to a request, so wdata only matters for writes.
    function automatic logic chan_mis(obi_req_t a, obi_req_t b);
        logic m;
        m = 1'b0;
        if (a.req != b.req) begin
            m = 1'b1;
        end else if (a.req) begin
            if ((a.addr != b.addr) || (a.we != b.we) || (a.be != b.be)) begin
                m = 1'b1;
            end else if (a.we && (a.wdata != b.wdata)) begin
                m = 1'b1;
            end
        end
        return m;
    endfunction

    assign instr_mis = chan_mis(req_if.instr_a, req_if.instr_b);
    assign data_mis  = chan_mis(req_if.data_a, req_if.data_b);
    assign cyc_mis   = instr_mis | data_mis;
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            warm_q  <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            src_q   <= '0;
            mis_q   <= 1'b0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            src_q   <= src_d;
            mis_q   <= mis_d;
            irq_q   <= irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        src_d   = src_q;
        mis_d   = 1'b0;
        irq_d   = 1'b0;

        if (clear_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            addr_d  = '0;
            src_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (enable_i) begin
                        state_d = ST_WARMUP;
                        warm_d  = '0;
                    end
                end
                ST_WARMUP: begin
                    if (!enable_i) begin
                        state_d = ST_IDLE;
                    end else if (warm_q == WARM_LAST) begin
                        state_d = ST_CHECK;
                    end else begin
                        warm_d = warm_q + WARM_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (!enable_i) begin
                        state_d = ST_IDLE;
                    end else if (cyc_mis) begin
                        mis_d = 1'b1;
                        cnt_d = cnt_inc;
                        if (cnt_inc >= CNT_THR) begin
                            state_d = ST_FAULT;
                            irq_d   = 1'b1;
                            addr_d  = data_mis ? req_if.data_a.addr : req_if.instr_a.addr;
                            src_d   = {data_mis, instr_mis};
                        end
                    end
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign mismatch_o     = mis_q;
    assign mismatch_cnt_o = cnt_q;
    assign fault_o        = (state_q == ST_FAULT);
    assign fault_irq_o    = irq_q;
    assign fault_addr_o   = addr_q;
    assign fault_src_o    = src_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_lockstep_compare.sv
// Directed bench: two checkers (threshold 1 and 3) share one stimulus stream.
module tb_lockstep_compare;
    import lockstep_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic clr = 1'b0;

    always #5 clk = ~clk;

    lockstep_compare_if bus();

    logic        mis1, f1, irq1, mis3, f3, irq3;
    logic [7:0]  cnt1, cnt3;
    logic [31:0] addr1, addr3;
    logic [1:0]  src1, src3, st1, st3;

    lockstep_compare #(.NCYCLES(2), .ERR_THRESHOLD(1), .CNT_W(8)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr), .req_if(bus),
        .mismatch_o(mis1), .mismatch_cnt_o(cnt1), .fault_o(f1), .fault_irq_o(irq1),
        .fault_addr_o(addr1), .fault_src_o(src1), .state_o(st1)
    );

    lockstep_compare #(.NCYCLES(2), .ERR_THRESHOLD(3), .CNT_W(8)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr), .req_if(bus),
        .mismatch_o(mis3), .mismatch_cnt_o(cnt3), .fault_o(f3), .fault_irq_o(irq3),
        .fault_addr_o(addr3), .fault_src_o(src3), .state_o(st3)
    );

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic obi_req_t mk(input logic req, input logic [31:0] addr, input logic we,
                                    input logic [3:0] be, input logic [31:0] wd);
        obi_req_t r;
        r.req = req; r.addr = addr; r.we = we; r.be = be; r.wdata = wd;
        return r;
    endfunction

    task automatic drive_eq(input obi_req_t i, input obi_req_t d);
        bus.instr_a = i; bus.instr_b = i;
        bus.data_a  = d; bus.data_b  = d;
    endtask

    obi_req_t ri, rd, rx;

    initial begin
        drive_eq('0, '0);
        repeat (3) step();
        chk("rst_state", 32'(st1), 32'd0);
        chk("rst_cnt", 32'(cnt1), 32'd0);
        chk("rst_fault", 32'(f1), 32'd0);
        chk("rst_irq", 32'(irq1), 32'd0);
        chk("rst_addr", addr1, 32'd0);
        rst = 1'b0;
        step();

        // Warm-up with disagreeing instruction requests: must be ignored.
        bus.instr_a = mk(1'b1, 32'h100, 1'b0, 4'hf, 32'h0);
        bus.instr_b = '0;
        en = 1'b1;
        step(); chk("warm_st_e", 32'(st1), 32'd1);
        step(); chk("warm_st_e1", 32'(st1), 32'd1); chk("warm_mis_e1", 32'(mis1), 32'd0);
        step(); chk("warm_st_e2", 32'(st1), 32'd2); chk("warm_cnt", 32'(cnt1), 32'd0);
        chk("warm_fault", 32'(f1), 32'd0); chk("warm_mis_e2", 32'(mis1), 32'd0);

        for (int k = 0; k < 100; k++) begin
            ri = mk(1'b1, $urandom, 1'b0, 4'hf, 32'h0);
            rd = mk(1'b1, $urandom, 1'b1, 4'(k), $urandom);
            drive_eq(ri, rd);
            step();
            chk("eq_mis1", 32'(mis1), 32'd0);
            chk("eq_mis3", 32'(mis3), 32'd0);
        end
        chk("eq_cnt1", 32'(cnt1), 32'd0);
        chk("eq_cnt3", 32'(cnt3), 32'd0);
        chk("eq_st1", 32'(st1), 32'd2);

        // Single data write mismatch.
        rd = mk(1'b1, 32'h1000_0040, 1'b1, 4'hf, 32'hCAFE_0001);
        rx = rd; rx.wdata = 32'hCAFE_0002;
        drive_eq(ri, rd); bus.data_b = rx;
        step();
        chk("df_fault", 32'(f1), 32'd1); chk("df_irq", 32'(irq1), 32'd1);
        chk("df_addr", addr1, 32'h1000_0040); chk("df_src", 32'(src1), 32'd2);
        chk("df_st", 32'(st1), 32'd3); chk("df_mis", 32'(mis1), 32'd1);
        chk("df_cnt1", 32'(cnt1), 32'd1);
        chk("df_cnt3", 32'(cnt3), 32'd1); chk("df_st3", 32'(st3), 32'd2);
        chk("df_f3", 32'(f3), 32'd0);
        drive_eq(ri, rd);
        step();
        chk("df_irq_off", 32'(irq1), 32'd0); chk("df_hold", 32'(f1), 32'd1);
        chk("df_mis_off", 32'(mis1), 32'd0); chk("df_cnt3b", 32'(cnt3), 32'd1);

        // Clear concurrently with a mismatch.
        bus.data_b = rx;
        clr = 1'b1;
        step();
        chk("clr_st", 32'(st1), 32'd0); chk("clr_cnt", 32'(cnt1), 32'd0);
        chk("clr_fault", 32'(f1), 32'd0); chk("clr_addr", addr1, 32'd0);
        chk("clr_src", 32'(src1), 32'd0); chk("clr_irq", 32'(irq1), 32'd0);
        chk("clr_cnt3", 32'(cnt3), 32'd0); chk("clr_irq3", 32'(irq3), 32'd0);
        chk("clr_mis3", 32'(mis3), 32'd0);
        clr = 1'b0;
        drive_eq(ri, rd);
        step(); chk("rearm_st", 32'(st1), 32'd1);
        step(); chk("rearm_st2", 32'(st1), 32'd1);
        step(); chk("rearm_st3", 32'(st1), 32'd2);

        // Read-masking: wdata differs but we=0.
        rd = mk(1'b1, 32'h3000_0000, 1'b0, 4'h3, 32'h1111_1111);
        rx = rd; rx.wdata = 32'h2222_2222;
        drive_eq(ri, rd); bus.data_b = rx;
        step();
        chk("rd_mis1", 32'(mis1), 32'd0); chk("rd_cnt1", 32'(cnt1), 32'd0);
        chk("rd_cnt3", 32'(cnt3), 32'd0);
        ri = mk(1'b1, 32'h2000_0010, 1'b0, 4'hf, 32'h0);
        drive_eq(ri, rd); bus.instr_b = '0;
        step();
        chk("im_fault", 32'(f1), 32'd1); chk("im_src", 32'(src1), 32'd1);
        chk("im_addr", addr1, 32'h2000_0010); chk("im_cnt3", 32'(cnt3), 32'd1);
        chk("im_mis3", 32'(mis3), 32'd1);

        // Threshold 3: enable drop with a concurrent mismatch is not counted.
        rx = rd; rx.addr = 32'h3000_0004;
        drive_eq(ri, rd); bus.data_b = rx;
        en = 1'b0;
        step();
        chk("en_st3", 32'(st3), 32'd0); chk("en_cnt3", 32'(cnt3), 32'd1);
        chk("en_mis3", 32'(mis3), 32'd0);
        chk("en_st1", 32'(st1), 32'd3); chk("en_f1", 32'(f1), 32'd1); chk("en_irq1", 32'(irq1), 32'd0);
        drive_eq(ri, rd);
        en = 1'b1;
        step(); chk("t3_w1", 32'(st3), 32'd1);
        step(); chk("t3_w2", 32'(st3), 32'd1);
        step(); chk("t3_chk", 32'(st3), 32'd2);
        rx = rd; rx.be = 4'h1;
        bus.data_b = rx;
        step();
        chk("t3_cnt2", 32'(cnt3), 32'd2); chk("t3_mis2", 32'(mis3), 32'd1);
        chk("t3_st2", 32'(st3), 32'd2); chk("t3_f2", 32'(f3), 32'd0);
        drive_eq(ri, rd);
        step();
        chk("t3_gap", 32'(mis3), 32'd0); chk("t3_cnt_gap", 32'(cnt3), 32'd2);
        rd = mk(1'b1, 32'h4000_0080, 1'b1, 4'hf, 32'h5555_0000);
        rx = rd; rx.wdata = 32'h5555_0001;
        drive_eq(ri, rd); bus.data_b = rx;
        step();
        chk("t3_cnt3", 32'(cnt3), 32'd3); chk("t3_st3", 32'(st3), 32'd3);
        chk("t3_f3", 32'(f3), 32'd1); chk("t3_irq", 32'(irq3), 32'd1);
        chk("t3_src", 32'(src3), 32'd2); chk("t3_addr", addr3, 32'h4000_0080);
        step();
        chk("t3_irq_off", 32'(irq3), 32'd0); chk("t3_frozen", 32'(cnt3), 32'd3);
        chk("t3_mis_off", 32'(mis3), 32'd0); chk("t3_addr_hold", addr3, 32'h4000_0080);
        en = 1'b0;
        step();
        chk("t3_en_f", 32'(f3), 32'd1); chk("t3_en_st", 32'(st3), 32'd3);

        clr = 1'b1;
        step();
        chk("fin_st3", 32'(st3), 32'd0); chk("fin_cnt3", 32'(cnt3), 32'd0);
        chk("fin_f3", 32'(f3), 32'd0); chk("fin_addr3", addr3, 32'd0);
        chk("fin_src3", 32'(src3), 32'd0); chk("fin_st1", 32'(st1), 32'd0);
        clr = 1'b0;
        en = 1'b1;
        drive_eq(ri, rd);
        step();
        chk("fin_rearm", 32'(st3), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
